eb_acc_dump: RTL and testbench

- Elastic integrate-and-dump decimator that sits directly downstream of an elastic buffer stage.
- Consumes signed samples on a valid/ready target port (t0_*).
- Sums each group of LEN accepted samples and emits one full-precision sum per group on a valid/ready initiator port (i0_*).
- Provides decimation-by-LEN with an elastic handshake on both sides.

---
 rtl/eb_acc_dump.sv | 78 +++++++
 tb/tb_eb_acc_dump.sv | 138 +++++++++++++
 2 files changed

// File: rtl/eb_acc_dump.sv
// eb_acc_dump: elastic integrate-and-dump decimator (sum of LEN samples per output); EB_ACC_DUMP_LAST_EN adds t0_last/i0_last
module eb_acc_dump #(
    parameter int WIDTH = 8,
    parameter int LEN = 4,
    localparam int OWIDTH = WIDTH + $clog2(LEN)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [WIDTH-1:0]  t0_data,
    input  logic                     t0_valid,
    output logic                     t0_ready,
`ifdef EB_ACC_DUMP_LAST_EN
    input  logic                     t0_last,
    output logic                     i0_last,
`endif
    output logic signed [OWIDTH-1:0] i0_data,
    output logic                     i0_valid,
    input  logic                     i0_ready
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic signed [OWIDTH-1:0] acc_q, acc_d, data_q, data_d, sum;
    logic valid_q, valid_d, t0_acc, done, cnt_end;
    assign cnt_end = cnt_q == CW'(LEN - 1);
    assign sum = acc_q + OWIDTH'(t0_data);
    assign t0_acc = t0_valid & t0_ready;
    assign i0_data = data_q;
    assign i0_valid = valid_q;
`ifdef EB_ACC_DUMP_LAST_EN
    logic last_q, last_d;
    assign t0_ready = (~cnt_end & ~(t0_valid & t0_last)) | ~valid_q | i0_ready;
    assign done = t0_acc & (cnt_end | t0_last);
    assign last_d = done ? t0_last : last_q;
    assign i0_last = last_q;
`else
    assign t0_ready = ~cnt_end | ~valid_q | i0_ready;
    assign done = t0_acc & cnt_end;
`endif
    // accumulate non-final samples; on completion load the sum, which may overlap a pop
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        data_d = data_q;
        valid_d = valid_q;
        if (done) begin
            data_d = sum;
            acc_d = '0;
            cnt_d = '0;
            valid_d = 1'b1;
        end else begin
            if (t0_acc) begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
            if (valid_q & i0_ready) valid_d = 1'b0;
        end
    end
    // state registers, reset discards any partial sum and pending output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
`ifdef EB_ACC_DUMP_LAST_EN
            last_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
            valid_q <= valid_d;
`ifdef EB_ACC_DUMP_LAST_EN
            last_q <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_eb_acc_dump.sv
// tb_eb_acc_dump: directed and random checks of eb_acc_dump against a queue-based group-sum model
module tb_eb_acc_dump;
    localparam int WIDTH = 8;
    localparam int LEN = 4;
    localparam int OW = WIDTH + $clog2(LEN);
`ifdef EB_ACC_DUMP_LAST_EN
    localparam bit HAS_LAST = 1'b1;
    logic i0_last;
`else
    localparam bit HAS_LAST = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic signed [WIDTH-1:0] t0_data = '0;
    logic t0_valid = 1'b0;
    logic t0_ready;
    logic t0_last = 1'b0;
    logic signed [OW-1:0] i0_data;
    logic i0_valid;
    logic i0_ready = 1'b0;
    int total = 0;
    int bad = 0;
    int grp[$];
    bit pv = 1'b0;
    int pd = 0;
    bit plast = 1'b0;

    eb_acc_dump #(.WIDTH(WIDTH), .LEN(LEN)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .t0_data(t0_data),
        .t0_valid(t0_valid),
        .t0_ready(t0_ready),
`ifdef EB_ACC_DUMP_LAST_EN
        .t0_last(t0_last),
        .i0_last(i0_last),
`endif
        .i0_data(i0_data),
        .i0_valid(i0_valid),
        .i0_ready(i0_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // one cycle: drive at negedge, check against the model, then advance the model past the posedge
    task automatic step(bit v, int d, bit r, bit l = 1'b0);
        bit rdy_m;
        int s;
        @(negedge clk);
        t0_valid = v;
        t0_data = WIDTH'(d);
        i0_ready = r;
        t0_last = l;
        #1;
        rdy_m = (grp.size() != LEN - 1 && !(HAS_LAST && v && l)) || !pv || r;
        chk("t0_ready", 32'(t0_ready), 32'(rdy_m));
        chk("i0_valid", 32'(i0_valid), 32'(pv));
        if (pv) chk("i0_data", 32'($signed(i0_data)), 32'(pd));
`ifdef EB_ACC_DUMP_LAST_EN
        if (pv) chk("i0_last", 32'(i0_last), 32'(plast));
`endif
        if (pv && r) pv = 1'b0;
        if (v && rdy_m) begin
            grp.push_back(int'(t0_data));
            if (grp.size() == LEN || (HAS_LAST && l)) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
                pd = s;
                pv = 1'b1;
                plast = l;
                grp.delete();
            end
        end
    endtask

    // asynchronous reset asserted away from any clock edge, checked before the next edge
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        t0_valid = 1'b0;
        #1;
        chk("rst_i0_valid", 32'(i0_valid), 32'd0);
        chk("rst_i0_data", 32'($signed(i0_data)), 32'd0);
        grp.delete();
        pv = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        async_reset();
        for (int i = 1; i <= 4; i++) step(1, i, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (4) step(1, -128, 1);
        step(0, 0, 1);
        repeat (4) step(1, 127, 1);
        step(0, 0, 1);
        for (int i = 1; i <= 7; i++) step(1, i, 0);
        step(1, 8, 0);
        step(1, 8, 0);
        step(1, 8, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, i, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (400) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, HAS_LAST && ($urandom_range(0, 7) == 0));
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (4) step(1, 9, 0);
        repeat (3) step(1, 1, 0);
        async_reset();
        repeat (4) step(1, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        if (HAS_LAST) begin
            step(1, 3, 1, 0);
            step(1, 4, 1, 1);
            step(0, 0, 1);
            repeat (4) step(1, 1, 1, 0);
            step(0, 0, 1);
            step(0, 0, 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
